// File: rtl/sbp_lookup_sched.sv
// sbp_lookup_sched
// Front-end scheduler for the non-stallable sbp_lookup stage pipeline.
// Accepts tagged IPv4 lookups (valid/ready), issues at most one per cycle on
// pipe_ip_o, tracks each issue slot through a PIPE_LAT-deep valid/tag delay
// line, and captures the aligned pipe_result_i into a show-ahead response
// FIFO. Issue is credit-limited so every in-flight lookup owns a FIFO slot.
//
// Ports
//   clk, rst_n                 clock, async active-low reset
//   enable_i                   0 stops new acceptance (in-flight work drains)
//   req_valid_i/req_ready_o    request handshake
//   req_ip_i, req_tag_i        request payload
//   pipe_ip_o                  address into the pipeline (0 on bubbles)
//   pipe_result_i              pipeline result, PIPE_LAT after issue
//   rsp_valid_o/rsp_ready_i    response handshake
//   rsp_result_o, rsp_tag_o    response payload (FIFO head)
//   inflight_o                 issued-but-not-popped count
//   busy_o                     inflight_o != 0
module sbp_lookup_sched #(
  parameter int PIPE_LAT   = 64,
  parameter int RES_BITS   = 17,
  parameter int TAG_BITS   = 8,
  parameter int FIFO_DEPTH = 64,
  localparam int AW = $clog2(FIFO_DEPTH),
  localparam int IW = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable_i,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic [31:0]         req_ip_i,
  input  logic [TAG_BITS-1:0] req_tag_i,
  output logic [31:0]         pipe_ip_o,
  input  logic [RES_BITS-1:0] pipe_result_i,
  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  output logic [RES_BITS-1:0] rsp_result_o,
  output logic [TAG_BITS-1:0] rsp_tag_o,
  output logic [IW-1:0]       inflight_o,
  output logic                busy_o
);

  typedef struct packed {
    logic [RES_BITS-1:0] result;
    logic [TAG_BITS-1:0] tag;
  } rsp_t;

  // issue state
  logic [31:0]                        r_pipe_ip;
  logic [PIPE_LAT-1:0]                r_vld_pipe;
  logic [PIPE_LAT-1:0][TAG_BITS-1:0]  r_tag_pipe;
  logic [IW-1:0]                      r_inflight;

  // response fifo
  rsp_t                               r_mem [FIFO_DEPTH];
  logic [AW:0]                        r_wr_ptr;
  logic [AW:0]                        r_rd_ptr;

  logic w_ready;
  logic w_accept;
  logic w_push;
  logic w_pop;
  logic w_empty;
  rsp_t w_head;
  rsp_t w_wdata;

  // Credit check uses only registered state, so ready never depends on valid.
  assign w_ready  = enable_i && (r_inflight < IW'(FIFO_DEPTH));
  assign w_accept = req_valid_i && w_ready;

  // Tail of the delay line lines up with the result for that issue slot.
  assign w_push   = r_vld_pipe[PIPE_LAT-1];
  assign w_empty  = (r_wr_ptr == r_rd_ptr);
  assign w_pop    = !w_empty && rsp_ready_i;

  assign w_wdata.result = pipe_result_i;
  assign w_wdata.tag    = r_tag_pipe[PIPE_LAT-1];
  assign w_head         = r_mem[r_rd_ptr[AW-1:0]];

  // rst_n gates only the output port so ready is low while reset is held,
  // even with enable_i high; internal flops are in reset then anyway.
  assign req_ready_o  = w_ready && rst_n;
  assign pipe_ip_o    = r_pipe_ip;
  assign rsp_valid_o  = !w_empty;
  assign rsp_result_o = w_head.result;
  assign rsp_tag_o    = w_head.tag;
  assign inflight_o   = r_inflight;
  assign busy_o       = (r_inflight != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pipe_ip  <= '0;
      r_vld_pipe <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_inflight <= '0;
    end else begin
      r_pipe_ip <= w_accept ? req_ip_i : 32'd0;
      for (int i = PIPE_LAT - 1; i > 0; i--) r_vld_pipe[i] <= r_vld_pipe[i-1];
      r_vld_pipe[0] <= w_accept;
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_inflight <= r_inflight + IW'(w_accept) - IW'(w_pop);
    end
  end

  // Tags ride alongside the valid bits; validity alone decides if a slot counts.
  always_ff @(posedge clk) begin
    for (int i = PIPE_LAT - 1; i > 0; i--) r_tag_pipe[i] <= r_tag_pipe[i-1];
    r_tag_pipe[0] <= req_tag_i;
  end

  // Credit guarantees a free slot on push; push into a full fifo cannot occur.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= w_wdata;
  end

endmodule
